// File: rtl/cache_perf_monitor.sv
// Per-channel data-cache access classifier with saturating event counters,
// a shared cycle counter and a registered one-cycle-latency readout port.

module cpm_lane #(
    parameter int CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  stall_i,
    input  logic                  idle_i,
    input  logic                  dirty_i,
    input  logic                  rd_acc_i,
    input  logic                  wr_acc_i,
    output logic [4:0]            evt_o,
    output logic [4:0][CNT_W-1:0] cnt_o,
    output logic                  ovf_o
);
    localparam int RH = 0, RM = 1, WH = 2, WM = 3, WB = 4;

    logic       pend;
    logic       miss_start, release_c;
    logic [4:0] ev;

    assign miss_start = stall_i & idle_i;
    assign release_c  = ~stall_i;

    always_comb begin
        ev     = '0;
        ev[WM] = miss_start & wr_acc_i;
        ev[RM] = miss_start & ~wr_acc_i & rd_acc_i;
        ev[WB] = miss_start & dirty_i & (rd_acc_i | wr_acc_i);
        // The release cycle of a miss is the refill completing, not a hit.
        ev[WH] = release_c & ~pend & wr_acc_i;
        ev[RH] = release_c & ~pend & ~wr_acc_i & rd_acc_i;
    end

    // Miss tracking ignores en/clr so that gating never fabricates a hit.
    always_ff @(posedge clk_i) begin
        if (!rst_i)          pend <= 1'b0;
        else if (miss_start) pend <= 1'b1;
        else if (release_c)  pend <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) evt_o <= '0;
        else        evt_o <= en_i ? ev : 5'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) begin
            cnt_o <= '0;
            ovf_o <= 1'b0;
        end else if (en_i) begin
            for (int k = 0; k < 5; k++) begin
                if (ev[k]) begin
                    if (&cnt_o[k]) ovf_o    <= 1'b1;
                    else           cnt_o[k] <= cnt_o[k] + 1'b1;
                end
            end
        end
    end
endmodule

module cache_perf_monitor #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [NUM_CH-1:0]     stall_i,
    input  logic [NUM_CH-1:0]     idle_i,
    input  logic [NUM_CH-1:0]     dirty_i,
    input  logic [NUM_CH-1:0]     rd_acc_i,
    input  logic [NUM_CH-1:0]     wr_acc_i,
    input  logic                  rd_req_i,
    input  logic [SEL_W-1:0]      rd_ch_i,
    input  logic [2:0]            rd_evt_i,
    output logic                  rd_valid_o,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic [5*NUM_CH-1:0]   evt_o,
    output logic [NUM_CH-1:0]     ovf_o
);
    logic [NUM_CH-1:0][4:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0][4:0]            evt;
    logic [CNT_W-1:0]                  cyc_cnt;
    logic [CNT_W-1:0]                  sel_val;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_lane
            cpm_lane #(.CNT_W(CNT_W)) u_lane (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .en_i     (en_i),
                .clr_i    (clr_i),
                .stall_i  (stall_i[c]),
                .idle_i   (idle_i[c]),
                .dirty_i  (dirty_i[c]),
                .rd_acc_i (rd_acc_i[c]),
                .wr_acc_i (wr_acc_i[c]),
                .evt_o    (evt[c]),
                .cnt_o    (cnt[c]),
                .ovf_o    (ovf_o[c])
            );
        end
    endgenerate

    assign evt_o = evt;

    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i)          cyc_cnt <= '0;
        else if (en_i && !(&cyc_cnt)) cyc_cnt <= cyc_cnt + 1'b1;
    end

    // Unmatched channel or event codes 6-7 fall through to zero.
    always_comb begin
        sel_val = '0;
        if (rd_evt_i == 3'd5) begin
            sel_val = cyc_cnt;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int k = 0; k < 5; k++)
                    if (rd_ch_i == SEL_W'(ch) && rd_evt_i == 3'(k))
                        sel_val = cnt[ch][k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) rd_data_o <= sel_val;
        end
    end
endmodule

// File: tb/tb_cache_perf_monitor.sv
// Randomized scoreboard bench for cache_perf_monitor against a counting model.

module tb_cache_perf_monitor;
    localparam int NC = 2;
    localparam int CW = 4;
    localparam int SW = 3;
    localparam int MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, en, clr, rd_req, rd_valid;
    logic [NC-1:0] stall, idle, dirty, rd_acc, wr_acc, ovf;
    logic [SW-1:0] rd_ch;
    logic [2:0] rd_evt;
    logic [CW-1:0] rd_data;
    logic [5*NC-1:0] evt;

    always #5 clk = ~clk;

    cache_perf_monitor #(.NUM_CH(NC), .CNT_W(CW), .SEL_W(SW)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
        .stall_i(stall), .idle_i(idle), .dirty_i(dirty),
        .rd_acc_i(rd_acc), .wr_acc_i(wr_acc),
        .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_evt_i(rd_evt),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .evt_o(evt), .ovf_o(ovf)
    );

    typedef struct {
        logic [5*NC-1:0] evt;
        logic [NC-1:0]   ovf;
        logic            vld;
        logic [CW-1:0]   data;
    } exp_t;

    exp_t q[$];
    int n_vec = 0, n_bad = 0;

    // Model state: plain event counts per channel/class
    int cnt_m[NC][5];
    int cyc_m;
    bit pend_m[NC];
    bit ovf_m[NC];
    logic [CW-1:0] last_m;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("evt_o", int'(evt), int'(e.evt));
            chk("ovf_o", int'(ovf), int'(e.ovf));
            chk("rd_valid_o", int'(rd_valid), int'(e.vld));
            chk("rd_data_o", int'(rd_data), int'(e.data));
        end
    end

    task automatic apply(input logic r, input logic e_n, input logic cl,
                         input logic [NC-1:0] st, input logic [NC-1:0] id,
                         input logic [NC-1:0] dt, input logic [NC-1:0] ra,
                         input logic [NC-1:0] wa, input logic rq,
                         input logic [SW-1:0] ch, input logic [2:0] ev_code);
        exp_t e;
        bit ev[NC][5];
        rst = r; en = e_n; clr = cl; stall = st; idle = id; dirty = dt;
        rd_acc = ra; wr_acc = wa; rd_req = rq; rd_ch = ch; rd_evt = ev_code;
        // Classify each channel's access this cycle (0 RH,1 RM,2 WH,3 WM,4 WB)
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < 5; k++) ev[c][k] = 0;
            if (st[c] && id[c]) begin
                if (wa[c]) ev[c][3] = 1; else if (ra[c]) ev[c][1] = 1;
                if (dt[c] && (ra[c] || wa[c])) ev[c][4] = 1;
            end else if (!st[c] && !pend_m[c]) begin
                if (wa[c]) ev[c][2] = 1; else if (ra[c]) ev[c][0] = 1;
            end
        end
        e.evt = '0; e.ovf = '0; e.vld = 1'b0;
        if (!r) begin
            for (int c = 0; c < NC; c++) begin
                pend_m[c] = 0; ovf_m[c] = 0;
                for (int k = 0; k < 5; k++) cnt_m[c][k] = 0;
            end
            cyc_m = 0; last_m = '0;
        end else begin
            if (rq) begin
                int v;
                if (ev_code == 3'd5) v = cyc_m;
                else if (ev_code < 3'd5 && int'(ch) < NC) v = cnt_m[int'(ch)][int'(ev_code)];
                else v = 0;
                last_m = CW'(v);
                e.vld = 1'b1;
            end
            for (int c = 0; c < NC; c++) begin
                if (e_n) for (int k = 0; k < 5; k++) e.evt[5*c+k] = ev[c][k];
                if (st[c] && id[c]) pend_m[c] = 1; else if (!st[c]) pend_m[c] = 0;
            end
            if (cl) begin
                for (int c = 0; c < NC; c++) begin
                    ovf_m[c] = 0;
                    for (int k = 0; k < 5; k++) cnt_m[c][k] = 0;
                end
                cyc_m = 0;
            end else if (e_n) begin
                for (int c = 0; c < NC; c++)
                    for (int k = 0; k < 5; k++)
                        if (ev[c][k]) begin
                            if (cnt_m[c][k] == MAXV) ovf_m[c] = 1;
                            else cnt_m[c][k]++;
                        end
                if (cyc_m < MAXV) cyc_m++;
            end
        end
        e.data = last_m;
        for (int c = 0; c < NC; c++) e.ovf[c] = ovf_m[c];
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rd(input logic rq, input logic [SW-1:0] ch, input logic [2:0] ev_code);
        apply(1, 1, 0, '0, '0, '0, '0, '0, rq, ch, ev_code);
    endtask

    initial begin
        #1;
        apply(0, 0, 0, '0, '0, '0, '0, '0, 0, 0, 0);
        apply(0, 1, 1, '1, '1, '1, '1, '1, 1, 0, 5);
        // Read miss with refill on ch0
        apply(1, 1, 0, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0);
        repeat (3) apply(1, 1, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0);
        apply(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0, 1);
        idle_rd(1, 0, 0);
        // Dirty write miss on ch1, then release
        apply(1, 1, 0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 0, 0, 0);
        apply(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1, 1, 3);
        idle_rd(1, 1, 4);
        idle_rd(1, 1, 2);
        // Hits with write priority, then reads only
        repeat (4) apply(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 0, 0, 0);
        repeat (2) apply(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0);
        idle_rd(1, 0, 2);
        idle_rd(1, 0, 0);
        idle_rd(1, 0, 5);
        // Saturation of ch0 RH, then clear
        repeat (17) apply(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0);
        idle_rd(1, 0, 0);
        apply(1, 1, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0, 0);
        idle_rd(1, 0, 0);
        // Gated miss start, enabled release
        apply(1, 0, 0, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0);
        apply(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0);
        idle_rd(1, 0, 1);
        idle_rd(1, 0, 0);
        idle_rd(1, 7, 0);
        idle_rd(1, 0, 6);
        // Reset mid-miss
        apply(1, 1, 0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0);
        apply(0, 1, 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 5);
        apply(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0);
        idle_rd(1, 1, 0);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic r, e_n, cl;
            r   = ($urandom_range(99) != 0);
            e_n = ($urandom_range(9) != 0);
            cl  = ($urandom_range(29) == 0);
            apply(r, e_n, cl, NC'($urandom), NC'($urandom), NC'($urandom),
                  NC'($urandom), NC'($urandom), 1'($urandom),
                  SW'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #6;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_perf_monitor.md
Name: cache_perf_monitor

Overview:
- Synthesizable, parametrised monitor that classifies data-cache accesses on NUM_CH cache ports.
- Classes: read hit, read miss, write hit, write miss, write-back. Each class has its own saturating counter per channel.
- Sits beside the dcache controllers in the CPU and watches their stall, idle-state, dirty and MemRead/MemWrite signals.
- Counters are read through a registered, one-cycle-latency readout port, so event statistics are available in hardware as well as in simulation logs.

Parameters:
- NUM_CH, 2, number of monitored cache channels (1..8).
- CNT_W, 32, width of every event counter and of the cycle counter.
- SEL_W, 3, channel-select width; must be at least clog2(NUM_CH), minimum 1.

Ports:
- clk_i  in  1  clock; everything is updated on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- en_i  in  1  counting enable.
- clr_i  in  1  synchronous clear of all counters, flags and overflow bits.
- stall_i  in  NUM_CH  per-channel cache stall (cpu_stall_o).
- idle_i  in  NUM_CH  per-channel cache FSM in idle state (state==0).
- dirty_i  in  NUM_CH  per-channel victim line dirty (sram_dirty).
- rd_acc_i  in  NUM_CH  per-channel MemRead.
- wr_acc_i  in  NUM_CH  per-channel MemWrite.
- rd_req_i  in  1  readout request.
- rd_ch_i  in  SEL_W  readout channel.
- rd_evt_i  in  3  readout event code.
- rd_valid_o  out  1  readout data valid.
- rd_data_o  out  CNT_W  readout value.
- evt_o  out  5*NUM_CH  registered event pulses. Channel c owns bits [5c+4:5c] = {WB, WM, WH, RM, RH}.
- ovf_o  out  NUM_CH  sticky overflow flag per channel.

Behaviour:
- Reset (rst_i==0 at an edge): all counters, pend flags, evt_o, ovf_o, rd_valid_o and rd_data_o go to 0. Reset has priority over every other input.
- Per-channel pend flag: marks a miss in progress so that the release cycle is not counted as a hit.
- Classification, evaluated every cycle per channel:
  - Miss start (stall & idle):
    - wr_acc → WM, else rd_acc → RM.
    - If dirty and (rd_acc|wr_acc), also WB in the same cycle.
    - pend <= 1, even when no access is asserted.
  - Hit/release (!stall):
    - If pend==0: wr_acc → WH, else rd_acc → RH.
    - pend <= 0.
  - Stall & !idle: no event, pend unchanged.
  - wr_acc has priority over rd_acc when both are high.
- Gating: pend tracking always runs, independent of en_i and clr_i; only reset clears pend. Counters increment and evt_o pulses are produced only when en_i==1.
- evt_o: one-cycle pulse, registered on the edge after the classifying cycle.
- Counters:
  - +1 per event, saturating at all-ones.
  - An increment attempted at all-ones sets ovf_o[c] sticky.
  - The cycle counter increments on every edge with en_i==1 and also saturates; it sets no ovf bit.
- Clear:
  - clr_i==1 zeroes all counters and ovf_o.
  - Clear wins over a simultaneous event: the counter reads 0 afterwards, not 1.
  - evt_o still pulses for an event in the clear cycle.
- Readout:
  - rd_req_i sampled at edge N → rd_valid_o=1 and rd_data_o valid after edge N, held for exactly one cycle. rd_data_o keeps its last value when rd_valid_o==0.
  - The value returned is the counter contents before edge N's update.
  - Event codes: 0 RH, 1 RM, 2 WH, 3 WM, 4 WB, 5 cycle counter (rd_ch_i ignored), 6-7 return 0.
  - rd_ch_i >= NUM_CH returns 0 with rd_valid_o still asserted.
  - Back-to-back requests are accepted every cycle.
- Channels are fully independent; simultaneous events on all channels are all counted.
- Reset mid-miss clears pend, so the next !stall cycle with an access counts as a hit.

Test Plan:
- Read miss with refill: en=1, ch0 stall=1 idle=1 rd_acc=1 dirty=0 for 1 cycle, then stall=1 idle=0 for 3 cycles, then stall=0 → RM=1, RH=0. One RM pulse on evt_o[1] only.
- Dirty write miss: ch1 stall=1 idle=1 wr_acc=1 dirty=1 → WM=1 and WB=1 in the same cycle; evt_o[8] and evt_o[9] pulse together. A following release cycle adds no WH.
- Hits and priority: ch0 stall=0, pend=0, rd_acc=1 and wr_acc=1 for 4 cycles → WH=4, RH=0. Then rd_acc only for 2 cycles → RH=2. Cycle counter = 6 plus any preceding enabled cycles.
- Saturation: force/preload CNT_W=4 build, 17 RH events → RH=15, ovf_o[0]=1. clr_i pulse → RH=0, ovf_o[0]=0.
- Clear vs event and gating:
  - clr_i=1 with an RH event → RH reads 0, evt_o still pulses.
  - en_i=0 during a miss start followed by en_i=1 at release → no RM and no RH counted (pend still tracked).
- Readout timing: request evt=5 at edge N, cycle count 10 before edge N → rd_valid_o=1 with 10 after edge N. rd_ch_i=7 with NUM_CH=2 → 0. rst_i=0 mid-stream → all outputs 0 on the next edge.
